// File: rtl/vxe_cu_ctl_pkg.sv
// Shared state encoding and datapath widths for the CU dispatch control sequencer.
package vxe_cu_ctl_pkg;

    localparam int unsigned AddrW = 37;
    localparam int unsigned CmdW  = 64;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StAck   = 2'd3
    } ctl_state_e;

endpackage

// File: rtl/vxe_cu_ctl_wdog.sv
// Drain watchdog: cleared while idle, counts while enabled, saturates at all-ones.
module vxe_cu_ctl_wdog #(
    parameter int unsigned TMO_POW2 = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [TMO_POW2-1:0] CntMax = '1;

    logic [TMO_POW2-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CntMax)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Fires on the cycle whose increment lands on the terminal count.
    assign o_expire = i_en && (r_cnt == (CntMax - 1'b1));

endmodule

// File: rtl/vxe_cu_dispatch_ctl.sv
// CU fetch/dispatch control sequencer: start, event acknowledge, stop-drain and fault reporting.
module vxe_cu_dispatch_ctl
    import vxe_cu_ctl_pkg::*;
#(
    parameter int unsigned TMO_POW2 = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [AddrW-1:0] i_start_addr,
    input  logic             i_halt_req,
    input  logic             i_err_clr,
    output logic             o_busy,
    output logic             o_fetch_start,
    output logic [AddrW-1:0] o_fetch_start_addr,
    output logic             o_fetch_stop_drain,
    input  logic             i_fetch_busy,
    input  logic             i_ctl_nop,
    input  logic             i_ctl_sync,
    input  logic             i_ctl_sync_stop,
    input  logic             i_ctl_sync_intr,
    input  logic             i_ctl_pipes_active,
    output logic             o_ctl_halt,
    output logic             o_ctl_unhalt,
    input  logic             i_flt_fetch,
    input  logic [AddrW-1:0] i_flt_fetch_addr,
    input  logic             i_flt_decode,
    input  logic [AddrW-1:0] i_flt_decode_addr,
    input  logic [CmdW-1:0]  i_flt_decode_data,
    output logic             o_err_fetch,
    output logic             o_err_decode,
    output logic             o_err_hang,
    output logic [AddrW-1:0] o_err_addr,
    output logic [CmdW-1:0]  o_err_data,
    output logic             o_intr_sync,
    output logic             o_intr_done,
    output logic             o_intr_err
);

    ctl_state_e       r_state;
    logic             r_err_flag;
    logic             r_busy;
    logic             r_fetch_start;
    logic [AddrW-1:0] r_fetch_start_addr;
    logic             r_fetch_stop_drain;
    logic             r_ctl_halt;
    logic             r_ctl_unhalt;
    logic             r_err_fetch;
    logic             r_err_decode;
    logic             r_err_hang;
    logic [AddrW-1:0] r_err_addr;
    logic [CmdW-1:0]  r_err_data;
    logic             r_intr_sync;
    logic             r_intr_done;
    logic             r_intr_err;

    logic w_flt_any;
    logic w_flt_window;
    logic w_capture;
    logic w_drained;
    logic w_wdog_en;
    logic w_wdog_clr;
    logic w_wdog_expire;

    assign w_flt_any    = i_flt_fetch | i_flt_decode;
    assign w_flt_window = (r_state == StRun) || (r_state == StDrain);
    // Only the first fault since the last clear is recorded.
    assign w_capture    = w_flt_any && w_flt_window && !r_err_fetch && !r_err_decode;
    assign w_drained    = !i_ctl_pipes_active && !i_fetch_busy;
    assign w_wdog_en    = (r_state == StDrain);
    assign w_wdog_clr   = !w_wdog_en;

    vxe_cu_ctl_wdog #(
        .TMO_POW2 (TMO_POW2)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_wdog_clr),
        .i_en     (w_wdog_en),
        .o_expire (w_wdog_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= StIdle;
            r_err_flag         <= 1'b0;
            r_busy             <= 1'b0;
            r_fetch_start      <= 1'b0;
            r_fetch_start_addr <= '0;
            r_fetch_stop_drain <= 1'b0;
            r_ctl_halt         <= 1'b0;
            r_ctl_unhalt       <= 1'b0;
            r_err_fetch        <= 1'b0;
            r_err_decode       <= 1'b0;
            r_err_hang         <= 1'b0;
            r_err_addr         <= '0;
            r_err_data         <= '0;
            r_intr_sync        <= 1'b0;
            r_intr_done        <= 1'b0;
            r_intr_err         <= 1'b0;
        end else begin
            r_fetch_start      <= 1'b0;
            r_fetch_stop_drain <= 1'b0;
            r_ctl_halt         <= 1'b0;
            r_ctl_unhalt       <= 1'b0;
            r_intr_sync        <= 1'b0;
            r_intr_done        <= 1'b0;
            r_intr_err         <= 1'b0;

            if (i_err_clr) begin
                r_err_fetch  <= 1'b0;
                r_err_decode <= 1'b0;
                r_err_hang   <= 1'b0;
                r_err_addr   <= '0;
                r_err_data   <= '0;
            end

            // Later assignments override the clear above.
            if (w_capture) begin
                r_err_fetch  <= i_flt_fetch;
                r_err_decode <= i_flt_decode;
                r_err_addr   <= i_flt_fetch ? i_flt_fetch_addr : i_flt_decode_addr;
                r_err_data   <= i_flt_fetch ? '0 : i_flt_decode_data;
            end

            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_fetch_start_addr <= i_start_addr;
                        r_fetch_start      <= 1'b1;
                        r_busy             <= 1'b1;
                        r_err_flag         <= 1'b0;
                        r_state            <= StRun;
                    end
                end
                StRun: begin
                    if (w_flt_any) begin
                        r_fetch_stop_drain <= 1'b1;
                        r_err_flag         <= 1'b1;
                        r_state            <= StDrain;
                    end else if (i_ctl_sync && i_ctl_sync_stop) begin
                        r_fetch_stop_drain <= 1'b1;
                        r_intr_sync        <= i_ctl_sync_intr;
                        r_state            <= StDrain;
                    end else if (i_halt_req) begin
                        r_ctl_halt         <= 1'b1;
                        r_fetch_stop_drain <= 1'b1;
                        r_state            <= StDrain;
                    end else if (i_ctl_sync) begin
                        r_ctl_unhalt <= 1'b1;
                        r_intr_sync  <= i_ctl_sync_intr;
                    end else if (i_ctl_nop) begin
                        r_ctl_unhalt <= 1'b1;
                    end
                end
                StDrain: begin
                    if (w_flt_any) begin
                        r_err_flag <= 1'b1;
                    end
                    // Completion pulses are registered on entry so they are visible during ACK.
                    if (w_drained) begin
                        r_ctl_unhalt <= 1'b1;
                        if (r_err_flag || w_flt_any) begin
                            r_intr_err <= 1'b1;
                        end else begin
                            r_intr_done <= 1'b1;
                        end
                        r_state <= StAck;
                    end else if (w_wdog_expire) begin
                        r_err_hang <= 1'b1;
                        r_intr_err <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= StIdle;
                    end
                end
                StAck: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_busy             = r_busy;
    assign o_fetch_start      = r_fetch_start;
    assign o_fetch_start_addr = r_fetch_start_addr;
    assign o_fetch_stop_drain = r_fetch_stop_drain;
    assign o_ctl_halt         = r_ctl_halt;
    assign o_ctl_unhalt       = r_ctl_unhalt;
    assign o_err_fetch        = r_err_fetch;
    assign o_err_decode       = r_err_decode;
    assign o_err_hang         = r_err_hang;
    assign o_err_addr         = r_err_addr;
    assign o_err_data         = r_err_data;
    assign o_intr_sync        = r_intr_sync;
    assign o_intr_done        = r_intr_done;
    assign o_intr_err         = r_intr_err;

endmodule

// File: tb/tb_vxe_cu_dispatch_ctl.sv
// Table-driven bench for vxe_cu_dispatch_ctl with a one-deep expected-output scoreboard.
module tb_vxe_cu_dispatch_ctl;

    localparam int unsigned TMO = 4;

    typedef struct packed {
        logic        rst;
        logic        start;
        logic [36:0] addr;
        logic        halt;
        logic        err_clr;
        logic        fbusy;
        logic        nop;
        logic        sync;
        logic        stop;
        logic        sintr;
        logic        pipes;
        logic        flt_f;
        logic [36:0] flt_f_addr;
        logic        flt_d;
        logic [36:0] flt_d_addr;
        logic [63:0] flt_d_data;
    } in_t;

    typedef struct packed {
        logic        busy;
        logic        fstart;
        logic [36:0] fsaddr;
        logic        stop_drain;
        logic        halt;
        logic        unhalt;
        logic        efetch;
        logic        edecode;
        logic        ehang;
        logic [36:0] eaddr;
        logic [63:0] edata;
        logic        isync;
        logic        idone;
        logic        ierr;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [36:0] i_start_addr;
    logic        i_halt_req;
    logic        i_err_clr;
    logic        o_busy;
    logic        o_fetch_start;
    logic [36:0] o_fetch_start_addr;
    logic        o_fetch_stop_drain;
    logic        i_fetch_busy;
    logic        i_ctl_nop;
    logic        i_ctl_sync;
    logic        i_ctl_sync_stop;
    logic        i_ctl_sync_intr;
    logic        i_ctl_pipes_active;
    logic        o_ctl_halt;
    logic        o_ctl_unhalt;
    logic        i_flt_fetch;
    logic [36:0] i_flt_fetch_addr;
    logic        i_flt_decode;
    logic [36:0] i_flt_decode_addr;
    logic [63:0] i_flt_decode_data;
    logic        o_err_fetch;
    logic        o_err_decode;
    logic        o_err_hang;
    logic [36:0] o_err_addr;
    logic [63:0] o_err_data;
    logic        o_intr_sync;
    logic        o_intr_done;
    logic        o_intr_err;

    vxe_cu_dispatch_ctl #(
        .TMO_POW2 (TMO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_start            (i_start),
        .i_start_addr       (i_start_addr),
        .i_halt_req         (i_halt_req),
        .i_err_clr          (i_err_clr),
        .o_busy             (o_busy),
        .o_fetch_start      (o_fetch_start),
        .o_fetch_start_addr (o_fetch_start_addr),
        .o_fetch_stop_drain (o_fetch_stop_drain),
        .i_fetch_busy       (i_fetch_busy),
        .i_ctl_nop          (i_ctl_nop),
        .i_ctl_sync         (i_ctl_sync),
        .i_ctl_sync_stop    (i_ctl_sync_stop),
        .i_ctl_sync_intr    (i_ctl_sync_intr),
        .i_ctl_pipes_active (i_ctl_pipes_active),
        .o_ctl_halt         (o_ctl_halt),
        .o_ctl_unhalt       (o_ctl_unhalt),
        .i_flt_fetch        (i_flt_fetch),
        .i_flt_fetch_addr   (i_flt_fetch_addr),
        .i_flt_decode       (i_flt_decode),
        .i_flt_decode_addr  (i_flt_decode_addr),
        .i_flt_decode_data  (i_flt_decode_data),
        .o_err_fetch        (o_err_fetch),
        .o_err_decode       (o_err_decode),
        .o_err_hang         (o_err_hang),
        .o_err_addr         (o_err_addr),
        .o_err_data         (o_err_data),
        .o_intr_sync        (o_intr_sync),
        .o_intr_done        (o_intr_done),
        .o_intr_err         (o_intr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    out_t got;
    always_comb begin
        got            = '0;
        got.busy       = o_busy;
        got.fstart     = o_fetch_start;
        got.fsaddr     = o_fetch_start_addr;
        got.stop_drain = o_fetch_stop_drain;
        got.halt       = o_ctl_halt;
        got.unhalt     = o_ctl_unhalt;
        got.efetch     = o_err_fetch;
        got.edecode    = o_err_decode;
        got.ehang      = o_err_hang;
        got.eaddr      = o_err_addr;
        got.edata      = o_err_data;
        got.isync      = o_intr_sync;
        got.idone      = o_intr_done;
        got.ierr       = o_intr_err;
    end

    vec_t  tbl[$];
    out_t  sb_exp[$];
    string sb_name[$];
    in_t   ci;
    out_t  ce;
    int    n_total;
    int    n_bad;

    // Record current stimulus/expectation; pulses and inputs return to zero for the next row.
    task automatic add(input string name);
        vec_t v;
        v.name = name;
        v.in   = ci;
        v.exp  = ce;
        tbl.push_back(v);
        ci            = '0;
        ce.fstart     = 1'b0;
        ce.stop_drain = 1'b0;
        ce.halt       = 1'b0;
        ce.unhalt     = 1'b0;
        ce.isync      = 1'b0;
        ce.idone      = 1'b0;
        ce.ierr       = 1'b0;
    endtask

    task automatic drive(input in_t v);
        rst                = v.rst;
        i_start            = v.start;
        i_start_addr       = v.addr;
        i_halt_req         = v.halt;
        i_err_clr          = v.err_clr;
        i_fetch_busy       = v.fbusy;
        i_ctl_nop          = v.nop;
        i_ctl_sync         = v.sync;
        i_ctl_sync_stop    = v.stop;
        i_ctl_sync_intr    = v.sintr;
        i_ctl_pipes_active = v.pipes;
        i_flt_fetch        = v.flt_f;
        i_flt_fetch_addr   = v.flt_f_addr;
        i_flt_decode       = v.flt_d;
        i_flt_decode_addr  = v.flt_d_addr;
        i_flt_decode_data  = v.flt_d_data;
    endtask

    task automatic check();
        out_t  e;
        string n;
        e = sb_exp.pop_front();
        n = sb_name.pop_front();
        n_total++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", n, got, e);
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        ci      = '0;
        ce      = '0;
        ci.rst  = 1'b1;
        drive(ci);

        // Reset and IDLE ignoring everything except start
        ci.rst = 1'b1; add("reset0");
        ci.rst = 1'b1; add("reset1");
        ci.halt = 1'b1; ci.nop = 1'b1; ci.sync = 1'b1; ci.flt_f = 1'b1;
        ci.flt_f_addr = 37'h12; ci.pipes = 1'b1; add("idle_ignores");

        // Start, NOP, start ignored in RUN
        ci.start = 1'b1; ci.addr = 37'h1;
        ce.busy = 1'b1; ce.fstart = 1'b1; ce.fsaddr = 37'h1; add("start");
        add("run_quiet");
        ci.nop = 1'b1; ce.unhalt = 1'b1; add("nop_unhalt");
        ci.start = 1'b1; ci.addr = 37'h77; add("start_ignored_in_run");

        // SYNC without stop
        ci.sync = 1'b1; ci.sintr = 1'b1; ce.unhalt = 1'b1; ce.isync = 1'b1; add("sync_intr");
        ci.sync = 1'b1; ce.unhalt = 1'b1; add("sync_plain");

        // SYNC stop with pipes busy for 5 cycles, then fetch busy for one
        ci.sync = 1'b1; ci.stop = 1'b1; ci.pipes = 1'b1; ce.stop_drain = 1'b1; add("sync_stop");
        for (int k = 0; k < 5; k++) begin
            ci.pipes = 1'b1; add("drain_wait");
        end
        ci.fbusy = 1'b1; add("drain_fetch_busy");
        ce.unhalt = 1'b1; ce.idone = 1'b1; add("drain_done");
        ce.busy = 1'b0; add("ack_to_idle");
        add("idle_after_stop");

        // Coincident faults (fetch wins), halt loses priority, later fault not captured
        ci.start = 1'b1; ci.addr = 37'h100;
        ce.busy = 1'b1; ce.fstart = 1'b1; ce.fsaddr = 37'h100; add("start2");
        ci.flt_f = 1'b1; ci.flt_f_addr = 37'h40; ci.flt_d = 1'b1; ci.flt_d_addr = 37'h38;
        ci.flt_d_data = 64'hdead_beef_0123_4567; ci.pipes = 1'b1; ci.halt = 1'b1;
        ce.stop_drain = 1'b1; ce.efetch = 1'b1; ce.edecode = 1'b1;
        ce.eaddr = 37'h40; ce.edata = '0; add("dual_fault");
        ci.flt_d = 1'b1; ci.flt_d_addr = 37'h99; ci.flt_d_data = 64'h1; ci.pipes = 1'b1;
        add("second_fault_kept");
        ce.unhalt = 1'b1; ce.ierr = 1'b1; add("fault_drain_done");
        ce.busy = 1'b0; add("fault_ack_idle");
        ci.err_clr = 1'b1; ce.efetch = 1'b0; ce.edecode = 1'b0;
        ce.eaddr = '0; ce.edata = '0; add("err_clr");

        // Decode-only fault arriving with a clear: capture wins
        ci.start = 1'b1; ci.addr = 37'h200;
        ce.busy = 1'b1; ce.fstart = 1'b1; ce.fsaddr = 37'h200; add("start3");
        ci.flt_d = 1'b1; ci.flt_d_addr = 37'h38; ci.flt_d_data = 64'hcafe_f00d_0000_0001;
        ci.err_clr = 1'b1;
        ce.stop_drain = 1'b1; ce.edecode = 1'b1; ce.eaddr = 37'h38;
        ce.edata = 64'hcafe_f00d_0000_0001; add("capture_beats_clr");
        ce.unhalt = 1'b1; ce.ierr = 1'b1; add("decode_drain_done");
        ci.err_clr = 1'b1; ce.busy = 1'b0; ce.edecode = 1'b0;
        ce.eaddr = '0; ce.edata = '0; add("clr_in_ack");

        // Halt with pipes stuck: hang after 15 DRAIN cycles, no unhalt
        ci.start = 1'b1; ci.addr = 37'h300;
        ce.busy = 1'b1; ce.fstart = 1'b1; ce.fsaddr = 37'h300; add("start4");
        ci.halt = 1'b1; ci.pipes = 1'b1; ce.halt = 1'b1; ce.stop_drain = 1'b1; add("halt_req");
        for (int k = 1; k < (1 << TMO) - 1; k++) begin
            ci.pipes = 1'b1; add("hang_wait");
        end
        ci.pipes = 1'b1; ce.ehang = 1'b1; ce.ierr = 1'b1; ce.busy = 1'b0; add("hang_expire");
        ci.pipes = 1'b1; add("hang_no_unhalt");
        ci.err_clr = 1'b1; ce.ehang = 1'b0; add("hang_clr");

        // Reset in DRAIN, then a normal run
        ci.start = 1'b1; ci.addr = 37'h400;
        ce.busy = 1'b1; ce.fstart = 1'b1; ce.fsaddr = 37'h400; add("start5");
        ci.flt_f = 1'b1; ci.flt_f_addr = 37'h44; ci.pipes = 1'b1;
        ce.stop_drain = 1'b1; ce.efetch = 1'b1; ce.eaddr = 37'h44; add("fetch_fault");
        ci.pipes = 1'b1; add("drain_hold");
        ci.rst = 1'b1; ci.pipes = 1'b1; ce = '0; add("reset_in_drain");
        ci.start = 1'b1; ci.addr = 37'h5;
        ce.busy = 1'b1; ce.fstart = 1'b1; ce.fsaddr = 37'h5; add("restart");
        ci.nop = 1'b1; ce.unhalt = 1'b1; add("restart_nop");
        ci.sync = 1'b1; ci.stop = 1'b1; ci.sintr = 1'b1; ci.halt = 1'b1;
        ce.stop_drain = 1'b1; ce.isync = 1'b1; add("sync_stop_intr");
        ce.unhalt = 1'b1; ce.idone = 1'b1; add("restart_drain_done");
        ce.busy = 1'b0; add("restart_idle");

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].in);
            sb_exp.push_back(tbl[k].exp);
            sb_name.push_back(tbl[k].name);
            @(posedge clk);
            #1;
            check();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
